// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Opcodes and tracker entry type shared by the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    // Register fields are 5 bits wide in this instruction format.
    localparam int REG_AW_ISA = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_ISA-1:0] dest;
        logic                  is_load;
    } trk_entry_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Decode-side inputs and pipeline-control outputs of the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      instr_dec;
    logic             dec_valid;
    logic             flush;
    logic             pc_enable;
    logic             ifid_enable;
    logic             idex_nop;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output instr_dec, dec_valid, flush,
        input  pc_enable, ifid_enable, idex_nop, stall_active, stall_cycles
    );

    modport slave (
        input  instr_dec, dec_valid, flush,
        output pc_enable, ifid_enable, idex_nop, stall_active, stall_cycles
    );
endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_scoreboard_decode.sv
`default_nettype none
// ============================================================================
// Module      : hazard_decode
// Description : Extracts source/destination registers of the decode instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_decode
    import hazard_pkg::*;
(
    input  wire logic [31:0]           instr_i,
    output logic      [REG_AW_ISA-1:0] rs_o,
    output logic                       rs_valid_o,
    output logic      [REG_AW_ISA-1:0] rt_o,
    output logic                       rt_valid_o,
    output logic      [REG_AW_ISA-1:0] dest_o,
    output logic                       dest_valid_o,
    output logic                       is_load_o
);
    logic w_rs_used;
    logic w_rt_used;
    logic w_dest_used;
    logic [REG_AW_ISA-1:0] w_dest;
    logic w_unused_bits;

    assign w_unused_bits = ^instr_i[10:0];

    always_comb begin
        w_rs_used   = 1'b0;
        w_rt_used   = 1'b0;
        w_dest_used = 1'b0;
        w_dest      = instr_i[20:16];
        is_load_o   = 1'b0;
        case (instr_i[31:26])
            OP_RTYPE: begin
                w_rs_used   = 1'b1;
                w_rt_used   = 1'b1;
                w_dest_used = 1'b1;
                w_dest      = instr_i[15:11];
            end
            OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: begin
                w_rs_used   = 1'b1;
                w_dest_used = 1'b1;
            end
            OP_LW: begin
                w_rs_used   = 1'b1;
                w_dest_used = 1'b1;
                is_load_o   = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                w_rs_used   = 1'b1;
                w_rt_used   = 1'b1;
            end
            OP_J, OP_NOP: begin
                w_rs_used   = 1'b0;
            end
            default: begin
                w_rs_used   = 1'b0;
            end
        endcase
    end

    // $0 is hard-wired, so it can never carry a dependency.
    assign rs_o         = instr_i[25:21];
    assign rt_o         = instr_i[20:16];
    assign dest_o       = w_dest;
    assign rs_valid_o   = w_rs_used   && (instr_i[25:21] != '0);
    assign rt_valid_o   = w_rt_used   && (instr_i[20:16] != '0);
    assign dest_valid_o = w_dest_used && (w_dest != '0);

endmodule : hazard_decode
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : RAW hazard detector with in-flight destination tracker and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int HAZ_DEPTH      = 2,
    parameter int FORWARDING     = 0,
    parameter int LOAD_USE_DEPTH = 1,
    parameter int CNT_W          = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hazard_scoreboard_if.slave  bus
);
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_dest;
    logic              w_rs_valid;
    logic              w_rt_valid;
    logic              w_dest_valid;
    logic              w_is_load;

    trk_entry_t        trk_q [1:HAZ_DEPTH];
    trk_entry_t        trk_d [1:HAZ_DEPTH];
    logic [HAZ_DEPTH:1] w_hit;

    logic              w_hazard;
    logic              w_stall;
    logic              w_issue;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    hazard_decode u_decode (
        .instr_i      (bus.instr_dec),
        .rs_o         (w_rs),
        .rs_valid_o   (w_rs_valid),
        .rt_o         (w_rt),
        .rt_valid_o   (w_rt_valid),
        .dest_o       (w_dest),
        .dest_valid_o (w_dest_valid),
        .is_load_o    (w_is_load)
    );

    generate
        for (genvar k = 1; k <= HAZ_DEPTH; k++) begin : g_stage
            if (k == 1) begin : g_head
                always_comb begin
                    trk_d[k] = '0;
                    if (w_issue) begin
                        trk_d[k].valid   = w_dest_valid;
                        trk_d[k].dest    = w_dest;
                        trk_d[k].is_load = w_is_load & w_dest_valid;
                    end
                end
            end else begin : g_body
                assign trk_d[k] = trk_q[k-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    trk_q[k] <= '0;
                end else begin
                    trk_q[k] <= trk_d[k];
                end
            end

            // With forwarding, only a load still in the leading stages is unreadable.
            logic w_in_window;
            if (FORWARDING == 0) begin : g_nofwd
                assign w_in_window = trk_q[k].valid;
            end else begin : g_fwd
                assign w_in_window = trk_q[k].valid && trk_q[k].is_load
                                     && (k <= LOAD_USE_DEPTH);
            end

            assign w_hit[k] = w_in_window &&
                              ((w_rs_valid && (w_rs == trk_q[k].dest)) ||
                               (w_rt_valid && (w_rt == trk_q[k].dest)));
        end
    endgenerate

    assign w_hazard = |w_hit;
    assign w_stall  = bus.dec_valid & w_hazard & ~bus.flush;
    assign w_issue  = bus.dec_valid & ~w_stall & ~bus.flush;

    assign cnt_d = (w_stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_active = w_stall;
    assign bus.pc_enable    = ~w_stall;
    assign bus.ifid_enable  = ~w_stall;
    assign bus.idex_nop     = ~w_issue;
    assign bus.stall_cycles = cnt_q;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Scoreboard bench over four parameter sets sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_instr = 32'hFC000000;
    logic        s_dv = 1'b0;
    logic        s_fl = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(8)) if0 ();
    hazard_scoreboard_if #(.CNT_W(8)) if1 ();
    hazard_scoreboard_if #(.CNT_W(8)) if2 ();
    hazard_scoreboard_if #(.CNT_W(2)) if3 ();

    assign if0.instr_dec = s_instr; assign if0.dec_valid = s_dv; assign if0.flush = s_fl;
    assign if1.instr_dec = s_instr; assign if1.dec_valid = s_dv; assign if1.flush = s_fl;
    assign if2.instr_dec = s_instr; assign if2.dec_valid = s_dv; assign if2.flush = s_fl;
    assign if3.instr_dec = s_instr; assign if3.dec_valid = s_dv; assign if3.flush = s_fl;

    hazard_scoreboard #(.HAZ_DEPTH(2), .FORWARDING(0), .LOAD_USE_DEPTH(1), .CNT_W(8))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    hazard_scoreboard #(.HAZ_DEPTH(2), .FORWARDING(1), .LOAD_USE_DEPTH(1), .CNT_W(8))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    hazard_scoreboard #(.HAZ_DEPTH(3), .FORWARDING(0), .LOAD_USE_DEPTH(1), .CNT_W(8))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    hazard_scoreboard #(.HAZ_DEPTH(2), .FORWARDING(0), .LOAD_USE_DEPTH(1), .CNT_W(2))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    localparam logic [31:0] ADDI1   = 32'h20010005; // addi $1,$0,5
    localparam logic [31:0] ADD2    = 32'h00211020; // add  $2,$1,$1
    localparam logic [31:0] ADD3    = 32'h00421820; // add  $3,$2,$2
    localparam logic [31:0] ADDI0   = 32'h20000001; // addi $0,$0,1
    localparam logic [31:0] ADD5    = 32'h00002820; // add  $5,$0,$0
    localparam logic [31:0] SW6     = 32'hACE60000; // sw   $6,0($7)
    localparam logic [31:0] ADD8    = 32'h00C74020; // add  $8,$6,$7
    localparam logic [31:0] BEQ12   = 32'h10220000; // beq  $1,$2
    localparam logic [31:0] LW3     = 32'h8C030000; // lw   $3,0($0)
    localparam logic [31:0] ADDI3   = 32'h20030000; // addi $3,$0,0
    localparam logic [31:0] ADD4    = 32'h00602020; // add  $4,$3,$0
    localparam logic [31:0] ORI9    = 32'h34090001; // ori  $9,$0,1
    localparam logic [31:0] ADDI11  = 32'h200B0001;
    localparam logic [31:0] ADDI12  = 32'h200C0001;
    localparam logic [31:0] ADDI13  = 32'h200D0001;
    localparam logic [31:0] AND10   = 32'h01295024; // and  $10,$9,$9
    localparam logic [31:0] NOPI    = 32'hFC000000;

    typedef struct {
        int         sel;
        logic       st;
        logic       nop;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cur_sel = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic drive(input logic r, input logic [31:0] ins, input logic dv,
                         input logic fl, input logic e_st, input logic e_nop,
                         input logic [7:0] e_cnt, input string name);
        exp_t e;
        rst     = r;
        s_instr = ins;
        s_dv    = dv;
        s_fl    = fl;
        e.sel = cur_sel; e.st = e_st; e.nop = e_nop; e.cnt = e_cnt; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        s_dv = 1'b0;
        s_fl = 1'b0;
        s_instr = NOPI;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pulls one expectation per cycle and compares the selected DUT.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            logic [4:0] req;
            logic [7:0] acnt;
            e = q.pop_front();
            case (e.sel)
                0: begin act = {if0.stall_active, if0.pc_enable, if0.ifid_enable, if0.idex_nop, 1'b0}; acnt = if0.stall_cycles; end
                1: begin act = {if1.stall_active, if1.pc_enable, if1.ifid_enable, if1.idex_nop, 1'b0}; acnt = if1.stall_cycles; end
                2: begin act = {if2.stall_active, if2.pc_enable, if2.ifid_enable, if2.idex_nop, 1'b0}; acnt = if2.stall_cycles; end
                default: begin act = {if3.stall_active, if3.pc_enable, if3.ifid_enable, if3.idex_nop, 1'b0}; acnt = {6'b0, if3.stall_cycles}; end
            endcase
            req = {e.st, ~e.st, ~e.st, e.nop, 1'b0};
            n_tests++;
            if (act !== req || acnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s: got stall/pc/ifid/nop=%b cnt=%0d, expected stall/pc/ifid/nop=%b cnt=%0d",
                         e.name, act[4:1], acnt, req[4:1], e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and T1: back-to-back RAW, default parameters
        cur_sel = 0;
        drive(0, NOPI,  0, 0, 0, 1, 0, "reset_idle");
        drive(0, ADDI1, 1, 0, 0, 0, 0, "t1_producer");
        drive(0, ADD2,  1, 0, 1, 1, 0, "t1_stall1");
        drive(0, ADD2,  1, 0, 1, 1, 1, "t1_stall2");
        drive(0, ADD2,  1, 0, 0, 0, 2, "t1_issue");
        drive(0, NOPI,  0, 0, 0, 1, 2, "t1_count");

        // T3: $0 and store destinations never create hazards
        do_reset();
        drive(0, ADDI0, 1, 0, 0, 0, 0, "t3_addi0");
        drive(0, ADD5,  1, 0, 0, 0, 0, "t3_read0");
        drive(0, SW6,   1, 0, 0, 0, 0, "t3_sw");
        drive(0, ADD8,  1, 0, 0, 0, 0, "t3_after_sw");

        // T4: flush overrides stall; producer keeps draining
        do_reset();
        drive(0, ADDI1, 1, 0, 0, 0, 0, "t4_producer");
        drive(0, BEQ12, 1, 1, 0, 1, 0, "t4_flush");
        drive(0, ADD2,  1, 0, 1, 1, 0, "t4_drain_stall");
        drive(0, ADD2,  1, 0, 0, 0, 1, "t4_issue");

        // T6: reset in the middle of a stall
        do_reset();
        drive(0, ADDI1, 1, 0, 0, 0, 0, "t6_producer");
        drive(0, ADD2,  1, 0, 1, 1, 0, "t6_stall1");
        drive(1, ADD2,  1, 0, 1, 1, 1, "t6_rst_cycle");
        drive(0, ADD2,  1, 0, 0, 0, 0, "t6_after_rst");

        // T2: forwarding, load-use only in stage 1
        cur_sel = 1;
        do_reset();
        drive(0, LW3,   1, 0, 0, 0, 0, "t2_lw");
        drive(0, ADD4,  1, 0, 1, 1, 0, "t2_loaduse");
        drive(0, ADD4,  1, 0, 0, 0, 1, "t2_issue");
        do_reset();
        drive(0, ADDI3, 1, 0, 0, 0, 0, "t2_alu");
        drive(0, ADD4,  1, 0, 0, 0, 0, "t2_fwd_nostall");

        // T5: HAZ_DEPTH=3, stall length = HAZ_DEPTH-k+1
        cur_sel = 2;
        do_reset();
        drive(0, ORI9,   1, 0, 0, 0, 0, "t5a_ori");
        drive(0, ADDI11, 1, 0, 0, 0, 0, "t5a_i1");
        drive(0, ADDI12, 1, 0, 0, 0, 0, "t5a_i2");
        drive(0, ADDI13, 1, 0, 0, 0, 0, "t5a_i3");
        drive(0, AND10,  1, 0, 0, 0, 0, "t5a_nostall");
        do_reset();
        drive(0, ORI9,   1, 0, 0, 0, 0, "t5b_ori");
        drive(0, ADDI11, 1, 0, 0, 0, 0, "t5b_i1");
        drive(0, ADDI12, 1, 0, 0, 0, 0, "t5b_i2");
        drive(0, AND10,  1, 0, 1, 1, 0, "t5b_stall_k3");
        drive(0, AND10,  1, 0, 0, 0, 1, "t5b_issue");
        do_reset();
        drive(0, ORI9,   1, 0, 0, 0, 0, "t5c_ori");
        drive(0, ADDI11, 1, 0, 0, 0, 0, "t5c_i1");
        drive(0, AND10,  1, 0, 1, 1, 0, "t5c_stall1");
        drive(0, AND10,  1, 0, 1, 1, 1, "t5c_stall2");
        drive(0, AND10,  1, 0, 0, 0, 2, "t5c_issue");

        // T6b: CNT_W=2 counter saturates at 3
        cur_sel = 3;
        do_reset();
        drive(0, ADDI1, 1, 0, 0, 0, 0, "t6b_producer");
        drive(0, ADD2,  1, 0, 1, 1, 0, "t6b_s1");
        drive(0, ADD2,  1, 0, 1, 1, 1, "t6b_s2");
        drive(0, ADD2,  1, 0, 0, 0, 2, "t6b_issue1");
        drive(0, ADD3,  1, 0, 1, 1, 2, "t6b_s3");
        drive(0, ADD3,  1, 0, 1, 1, 3, "t6b_s4");
        drive(0, ADD3,  1, 0, 0, 0, 3, "t6b_sat");
        drive(0, NOPI,  0, 0, 0, 1, 3, "t6b_hold");

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
